// File: rtl/add64_pkg.sv
// add64_pkg: shared widths and FSM state encoding for the add64_scheduler slice.
package add64_pkg;

    localparam int unsigned HALF_W = 32;
    localparam int unsigned FULL_W = 64;

    // One pass per state: accept, low half, high half, carry fix-up, response.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LO   = 3'd1,
        HI   = 3'd2,
        INC  = 3'd3,
        RESP = 3'd4
    } state_t;

endpackage

// File: rtl/carry_look_ahead_adder.sv
// carry_look_ahead_adder: 32-bit two-level carry look-ahead adder, no carry-in.
// Bits are grouped in nibbles; each nibble produces group generate/propagate,
// and group carries are chained so each bit carry is a short sum of products.
module carry_look_ahead_adder
    import add64_pkg::*;
(
    input  logic [HALF_W-1:0] A,
    input  logic [HALF_W-1:0] B,
    output logic [HALF_W-1:0] S,
    output logic              C
);

    localparam int unsigned NGRP = HALF_W / 4;

    logic [HALF_W-1:0] g;
    logic [HALF_W-1:0] p;
    logic [HALF_W-1:0] c;
    logic [NGRP-1:0]   gg;
    logic [NGRP-1:0]   gp;
    logic [NGRP:0]     gc;

    // Bit and group generate/propagate, group carries, then per-bit carries and sum.
    always_comb begin
        g  = A & B;
        p  = A ^ B;
        gg = '0;
        gp = '0;
        gc = '0;
        c  = '0;
        for (int unsigned k = 0; k < NGRP; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end
        for (int unsigned k = 0; k < NGRP; k++) begin
            gc[k+1] = gg[k] | (gp[k] & gc[k]);
        end
        for (int unsigned k = 0; k < NGRP; k++) begin
            c[4*k]   = gc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
        end
        S = p ^ c;
        C = gc[NGRP];
    end

endmodule

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin grant; pointer picks the winner on contention.
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       pointer,
    output logic [1:0] grant
);

    // One-hot grant: a lone requester always wins, the pointer breaks ties.
    always_comb begin
        grant = '0;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = pointer ? 2'b10 : 2'b01;
            default: grant = '0;
        endcase
    end

endmodule

// File: rtl/add64_scheduler.sv
// add64_scheduler: two requesters share one 32-bit CLA to form 64-bit sums in
// LO / HI / optional INC passes, returning the result with a valid/ready handshake.
// Optional: define ADD64_OVF_FLAG_EN to add the rsp_ovf signed-overflow output.
module add64_scheduler
    import add64_pkg::*;
#(
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [FULL_W-1:0] req0_a,
    input  logic [FULL_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [FULL_W-1:0] req1_a,
    input  logic [FULL_W-1:0] req1_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [FULL_W-1:0] rsp_sum,
    output logic              rsp_cout
`ifdef ADD64_OVF_FLAG_EN
    ,
    output logic              rsp_ovf
`endif
);

    state_t            state;
    logic              pointer;
    logic [FULL_W-1:0] op_a;
    logic [FULL_W-1:0] op_b;
    logic [FULL_W-1:0] sum_q;
    logic              c_lo;
    logic              c_hi;
    logic              cout_q;
    logic              id_q;
    logic              rsp_valid_q;
    logic [1:0]        grant;
    logic [HALF_W-1:0] add_a;
    logic [HALF_W-1:0] add_b;
    logic [HALF_W-1:0] add_s;
    logic              add_c;
`ifdef ADD64_OVF_FLAG_EN
    logic              ovf_q;
`endif

    rr_arbiter2 u_arb (
        .valid   ({req1_valid, req0_valid}),
        .pointer (pointer),
        .grant   (grant)
    );

    carry_look_ahead_adder u_cla (
        .A (add_a),
        .B (add_b),
        .S (add_s),
        .C (add_c)
    );

    // Ready only in IDLE for the granted requester; forced low while reset is asserted.
    always_comb begin
        req0_ready = rst_n && (state == IDLE) && grant[0];
        req1_ready = rst_n && (state == IDLE) && grant[1];
    end

    // Steer the shared adder according to the current pass.
    always_comb begin
        add_a = '0;
        add_b = '0;
        case (state)
            LO: begin
                add_a = op_a[HALF_W-1:0];
                add_b = op_b[HALF_W-1:0];
            end
            HI: begin
                add_a = op_a[FULL_W-1:HALF_W];
                add_b = op_b[FULL_W-1:HALF_W];
            end
            INC: begin
                add_a = sum_q[FULL_W-1:HALF_W];
                add_b = {{(HALF_W-1){1'b0}}, 1'b1};
            end
            default: begin
                add_a = '0;
                add_b = '0;
            end
        endcase
    end

    // Sequencer: accept, low pass, high pass, optional low-carry increment, respond.
    // The low-half carry is applied as a separate +1 on the upper half rather than
    // as a carry-in, so the adder keeps a carry-in-free interface.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pointer     <= PRIO_INIT;
            op_a        <= '0;
            op_b        <= '0;
            sum_q       <= '0;
            c_lo        <= 1'b0;
            c_hi        <= 1'b0;
            cout_q      <= 1'b0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
`ifdef ADD64_OVF_FLAG_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req0_valid && req0_ready) begin
                        op_a  <= req0_a;
                        op_b  <= req0_b;
                        id_q  <= 1'b0;
                        state <= LO;
                    end else if (req1_valid && req1_ready) begin
                        op_a  <= req1_a;
                        op_b  <= req1_b;
                        id_q  <= 1'b1;
                        state <= LO;
                    end
                end
                LO: begin
                    sum_q[HALF_W-1:0] <= add_s;
                    c_lo              <= add_c;
                    state             <= HI;
                end
                HI: begin
                    sum_q[FULL_W-1:HALF_W] <= add_s;
                    c_hi                   <= add_c;
                    if (c_lo) begin
                        state <= INC;
                    end else begin
                        cout_q      <= add_c;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
`ifdef ADD64_OVF_FLAG_EN
                        ovf_q <= (op_a[FULL_W-1] == op_b[FULL_W-1]) &&
                                 (add_s[HALF_W-1] != op_a[FULL_W-1]);
`endif
                    end
                end
                INC: begin
                    sum_q[FULL_W-1:HALF_W] <= add_s;
                    cout_q                 <= c_hi | add_c;
                    rsp_valid_q            <= 1'b1;
                    state                  <= RESP;
`ifdef ADD64_OVF_FLAG_EN
                    ovf_q <= (op_a[FULL_W-1] == op_b[FULL_W-1]) &&
                             (add_s[HALF_W-1] != op_a[FULL_W-1]);
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        pointer     <= ~id_q;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Response outputs come straight from the registers, so they hold while stalled.
    always_comb begin
        rsp_valid = rsp_valid_q;
        rsp_id    = id_q;
        rsp_sum   = sum_q;
        rsp_cout  = cout_q;
`ifdef ADD64_OVF_FLAG_EN
        rsp_ovf   = ovf_q;
`endif
    end

endmodule

// File: tb/tb_add64_scheduler.sv
// tb_add64_scheduler: table-driven vectors plus hand sequences for arbitration,
// response stall and mid-operation reset; expected results flow through a queue.
module tb_add64_scheduler;

    logic        clk;
    logic        rst_n;
    logic        req0_valid;
    logic        req0_ready;
    logic [63:0] req0_a;
    logic [63:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [63:0] req1_a;
    logic [63:0] req1_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [63:0] rsp_sum;
    logic        rsp_cout;
`ifdef ADD64_OVF_FLAG_EN
    logic        rsp_ovf;
`endif

    add64_scheduler #(.PRIO_INIT(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout)
`ifdef ADD64_OVF_FLAG_EN
        ,
        .rsp_ovf    (rsp_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        int unsigned lat;
    } exp_t;

    typedef struct {
        logic        id;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        int unsigned lat;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[9];
    int unsigned n_checks;
    int unsigned n_fail;

    task automatic chk_bit(input string name, input logic act, input logic req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    task automatic chk_word(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference: plain 65-bit addition; INC pass happens when the low halves carry.
    function automatic exp_t model(input logic id, input logic [63:0] a, input logic [63:0] b);
        logic [64:0] s;
        logic [32:0] lo;
        exp_t        e;
        s      = {1'b0, a} + {1'b0, b};
        lo     = {1'b0, a[31:0]} + {1'b0, b[31:0]};
        e.id   = id;
        e.sum  = s[63:0];
        e.cout = s[64];
        e.ovf  = (a[63] == b[63]) && (s[63] != a[63]);
        e.lat  = lo[32] ? 4 : 3;
        return e;
    endfunction

    task automatic drive_req(input logic id, input logic [63:0] a, input logic [63:0] b, input logic v);
        if (id == 1'b0) begin
            req0_valid = v;
            req0_a     = a;
            req0_b     = b;
        end else begin
            req1_valid = v;
            req1_a     = a;
            req1_b     = b;
        end
    endtask

    // sel: 0/1 waits for that requester's ready, 2 waits for either.
    task automatic wait_ready(input int sel);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            #1;
            if ((sel == 0 && req0_ready) || (sel == 1 && req1_ready) ||
                (sel == 2 && (req0_ready || req1_ready))) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk_bit("ready_granted", ok, 1'b1);
    endtask

    task automatic pop_cmp(input int unsigned cyc);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: got response id %0d sum %h expected no response", rsp_id, rsp_sum);
        end else begin
            e = sb.pop_front();
            chk_bit("rsp_id", rsp_id, e.id);
            chk_word("rsp_sum", rsp_sum, e.sum);
            chk_bit("rsp_cout", rsp_cout, e.cout);
            chk_word("latency", 64'(cyc), 64'(e.lat));
`ifdef ADD64_OVF_FLAG_EN
            chk_bit("rsp_ovf", rsp_ovf, e.ovf);
`endif
        end
    endtask

    // Called right after the accepting edge; counts cycles until rsp_valid.
    task automatic collect();
        int unsigned cyc;
        bit          seen;
        bit          busy;
        cyc  = 0;
        seen = 1'b0;
        busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
            if (req0_ready || req1_ready) busy = 1'b1;
        end
        chk_bit("rsp_valid_arrives", rsp_valid, 1'b1);
        chk_bit("ready_low_while_busy", busy, 1'b0);
        if (seen) pop_cmp(cyc);
    endtask

    task automatic run_op(input logic id, input logic [63:0] a, input logic [63:0] b, input exp_t e);
        drive_req(id, a, b, 1'b1);
        wait_ready(int'(id));
        sb.push_back(e);
        @(posedge clk);
        #1;
        drive_req(id, ~a, ~b, 1'b0);
        collect();
        @(posedge clk);
        #1;
        chk_bit("rsp_valid_dropped", rsp_valid, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        exp_t        e;
        logic [63:0] a0, b0, a1, b1;
        logic        exp_id;
        bit          drop, pulse, seen;
        int unsigned cyc;

        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        rsp_ready  = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_a     = 64'h1;
        req0_b     = 64'h2;
        req1_a     = 64'h3;
        req1_b     = 64'h4;

        //                 id    a                       b                       sum                     cout  ovf   lat
        vecs[0] = '{1'b0, 64'h0000_0001_FFFF_FFFF, 64'h0000_0000_0000_0001, 64'h0000_0002_0000_0000, 1'b0, 1'b0, 4};
        vecs[1] = '{1'b1, 64'h1234_5678_0000_0001, 64'h1111_1111_0000_0002, 64'h2345_6789_0000_0003, 1'b0, 1'b0, 3};
        vecs[2] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0000, 1'b1, 1'b0, 4};
        vecs[3] = '{1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 4};
        vecs[4] = '{1'b0, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b0, 1'b0, 3};
        vecs[5] = '{1'b1, 64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000, 64'h0000_0000_0000_0000, 1'b1, 1'b0, 3};
        vecs[6] = '{1'b0, 64'hFFFF_FFFF_8000_0000, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0000, 1'b1, 1'b0, 4};
        vecs[7] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 4};
        vecs[8] = '{1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b1, 1'b1, 3};

        // Reset state with both requesters pushing.
        #1;
        chk_bit("reset_rsp_valid", rsp_valid, 1'b0);
        chk_bit("reset_req0_ready", req0_ready, 1'b0);
        chk_bit("reset_req1_ready", req1_ready, 1'b0);
        chk_bit("reset_rsp_id", rsp_id, 1'b0);
        chk_word("reset_rsp_sum", rsp_sum, 64'h0);
        chk_bit("reset_rsp_cout", rsp_cout, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        do_reset();

        // Table vectors, one requester at a time.
        for (int i = 0; i < 9; i++) begin
            e.id   = vecs[i].id;
            e.sum  = vecs[i].sum;
            e.cout = vecs[i].cout;
            e.ovf  = vecs[i].ovf;
            e.lat  = vecs[i].lat;
            run_op(vecs[i].id, vecs[i].a, vecs[i].b, e);
        end

        // Both requesters valid from reset: grants alternate starting at 0.
        do_reset();
        a0 = {$urandom, $urandom};
        b0 = {$urandom, $urandom};
        a1 = {$urandom, $urandom};
        b1 = {$urandom, $urandom};
        drive_req(1'b0, a0, b0, 1'b1);
        drive_req(1'b1, a1, b1, 1'b1);
        exp_id = 1'b0;
        for (int n = 0; n < 4; n++) begin
            wait_ready(2);
            chk_bit("rr_grant0", req0_ready, exp_id == 1'b0);
            chk_bit("rr_grant1", req1_ready, exp_id == 1'b1);
            if (exp_id == 1'b0) sb.push_back(model(1'b0, a0, b0));
            else                sb.push_back(model(1'b1, a1, b1));
            @(posedge clk);
            #1;
            if (exp_id == 1'b0) begin
                a0 = {$urandom, $urandom};
                b0 = {$urandom, $urandom};
                drive_req(1'b0, a0, b0, 1'b1);
            end else begin
                a1 = {$urandom, $urandom};
                b1 = {$urandom, $urandom};
                drive_req(1'b1, a1, b1, 1'b1);
            end
            collect();
            exp_id = ~exp_id;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        #1;

        // Stalled response: held 10 cycles with a waiting requester, then released.
        a0 = 64'h0000_0000_FFFF_FFFF;
        b0 = 64'h0000_0000_0000_0002;
        a1 = 64'h0000_0003_0000_0004;
        b1 = 64'h0000_0005_0000_0006;
        e  = model(1'b0, a0, b0);
        rsp_ready = 1'b0;
        drive_req(1'b0, a0, b0, 1'b1);
        wait_ready(0);
        sb.push_back(e);
        @(posedge clk);
        #1;
        drive_req(1'b0, 64'h0, 64'h0, 1'b0);
        drive_req(1'b1, a1, b1, 1'b1);
        cyc  = 0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk_bit("stall_rsp_valid", rsp_valid, 1'b1);
        drop  = 1'b0;
        pulse = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_sum !== e.sum || rsp_id !== e.id || rsp_cout !== e.cout) drop = 1'b1;
            if (req0_ready || req1_ready) pulse = 1'b1;
        end
        chk_bit("stall_outputs_stable", drop, 1'b0);
        chk_bit("stall_no_ready", pulse, 1'b0);
        if (seen) pop_cmp(cyc);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk_bit("release_rsp_valid", rsp_valid, 1'b0);
        chk_bit("release_idle_ready", req1_ready, 1'b1);
        run_op(1'b1, a1, b1, model(1'b1, a1, b1));

        // Reset while in HI discards the operation.
        drive_req(1'b0, vecs[1].a, vecs[1].b, 1'b1);
        wait_ready(0);
        sb.push_back(model(1'b0, vecs[1].a, vecs[1].b));
        @(posedge clk);
        #1;
        drive_req(1'b0, 64'h0, 64'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_bit("midreset_rsp_valid", rsp_valid, 1'b0);
        chk_word("midreset_rsp_sum", rsp_sum, 64'h0);
        chk_bit("midreset_rsp_cout", rsp_cout, 1'b0);
        chk_bit("midreset_rsp_id", rsp_id, 1'b0);
        chk_bit("midreset_req0_ready", req0_ready, 1'b0);
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drop = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid) drop = 1'b1;
        end
        chk_bit("midreset_no_response", drop, 1'b0);
        e.id   = vecs[0].id;
        e.sum  = vecs[0].sum;
        e.cout = vecs[0].cout;
        e.ovf  = vecs[0].ovf;
        e.lat  = vecs[0].lat;
        run_op(vecs[0].id, vecs[0].a, vecs[0].b, e);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
